i2c_slave_ctrl: RTL

Downstream consumer of the I2C slave decode stage in the I2C/Triple-DES project.
- Takes start_found/stop_found from decode and tracks the I2C bus protocol.
- Shifts in the address byte and presents it as starting_byte. Decode combinationally returns address_match and rw_mode.
- Generates slave ACK, receives write data bytes and serialises read data bytes onto SDA.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_slave_ctrl_if.sv | 38 +++
 rtl/scl_edge.sv | 41 ++++
 rtl/i2c_slave_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C slave controller and decode
// Purpose: controller state encoding and the slave address that decode compares against.
// Ports: none (package).
package i2c_pkg;

  // 7-bit slave address; decode matches starting_byte[7:1] against this.
  localparam logic [6:0] SLAVE_ADDR = 7'b1111000;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_DEC,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_CHK,
    WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_slave_ctrl_if.sv
// rtl/i2c_slave_ctrl_if.sv - bus/handshake bundle between the I2C slave controller and its neighbours
// Purpose: groups the raw I2C lines, the decode handshake and the byte-level data handshake.
// Ports (slave modport view):
//   in : scl, sda_in, start_found, stop_found, address_match, rw_mode, tx_data
//   out: starting_byte, rx_data, rx_valid, tx_load, tx_nack, sda_out, sda_oe, busy
interface i2c_slave_ctrl_if #(
  parameter int NBITS = 8
);

  logic             scl;
  logic             sda_in;
  logic             start_found;
  logic             stop_found;
  logic             address_match;
  logic             rw_mode;
  logic [NBITS-1:0] starting_byte;
  logic [NBITS-1:0] rx_data;
  logic             rx_valid;
  logic [NBITS-1:0] tx_data;
  logic             tx_load;
  logic             tx_nack;
  logic             sda_out;
  logic             sda_oe;
  logic             busy;

  // Controller side.
  modport slave (
    input  scl, sda_in, start_found, stop_found, address_match, rw_mode, tx_data,
    output starting_byte, rx_data, rx_valid, tx_load, tx_nack, sda_out, sda_oe, busy
  );

  // Environment side (decode, data source/sink, bus).
  modport master (
    output scl, sda_in, start_found, stop_found, address_match, rw_mode, tx_data,
    input  starting_byte, rx_data, rx_valid, tx_load, tx_nack, sda_out, sda_oe, busy
  );

endinterface

// File: rtl/scl_edge.sv
// rtl/scl_edge.sv - scl/sda synchroniser with scl edge detection
// Purpose: brings raw scl/sda into the clk domain and flags scl edges for one cycle.
// Ports:
//   clk, n_rst       : clock, asynchronous active-low reset
//   scl, sda_in      : raw I2C lines
//   scl_rise/fall    : 1-cycle pulses on synchronised scl edges
//   sda_sync         : sda delayed by the same chain depth as scl
module scl_edge #(
  parameter int SYNC_DEPTH = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic scl,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_sync
);

  logic [SYNC_DEPTH-1:0] scl_sh;
  logic [SYNC_DEPTH-1:0] sda_sh;
  logic                  scl_prev;

  // Chains reset to 1 (idle bus) so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      scl_sh   <= '1;
      sda_sh   <= '1;
      scl_prev <= 1'b1;
    end else begin
      scl_sh   <= {scl_sh[SYNC_DEPTH-2:0], scl};
      sda_sh   <= {sda_sh[SYNC_DEPTH-2:0], sda_in};
      scl_prev <= scl_sh[SYNC_DEPTH-1];
    end
  end

  assign scl_rise = scl_sh[SYNC_DEPTH-1] & ~scl_prev;
  assign scl_fall = ~scl_sh[SYNC_DEPTH-1] & scl_prev;
  assign sda_sync = sda_sh[SYNC_DEPTH-1];

endmodule

// File: rtl/i2c_slave_ctrl.sv
// rtl/i2c_slave_ctrl.sv - I2C slave protocol controller downstream of the decode stage
// Purpose: tracks the bus, captures the address byte, ACKs, receives write bytes and
//          serialises read bytes onto SDA (open-drain: only zeros are driven).
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : i2c_slave_ctrl_if.slave (raw lines, decode handshake, byte handshake)
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter int SYNC_DEPTH = 3,
  parameter int NBITS      = 8
) (
  input logic              clk,
  input logic              n_rst,
  i2c_slave_ctrl_if.slave  bus
);

  localparam int               CNT_W    = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  // Second half of a two-step state: ACK driven / last bit seen / master ACK seen.
  logic             phase;
  logic [NBITS-2:0] rx_shift;
  logic [NBITS-2:0] tx_shift;   // remaining bits after the MSB has been driven

  logic scl_rise;
  logic scl_fall;
  logic sda_sync;

  scl_edge #(
    .SYNC_DEPTH (SYNC_DEPTH)
  ) u_scl_edge (
    .clk      (clk),
    .n_rst    (n_rst),
    .scl      (bus.scl),
    .sda_in   (bus.sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_sync (sda_sync)
  );

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state             <= IDLE;
      bit_cnt           <= '0;
      phase             <= 1'b0;
      rx_shift          <= '0;
      tx_shift          <= '0;
      bus.starting_byte <= '0;
      bus.rx_data       <= '0;
      bus.rx_valid      <= 1'b0;
      bus.tx_load       <= 1'b0;
      bus.tx_nack       <= 1'b0;
      bus.sda_out       <= 1'b1;
      bus.sda_oe        <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.tx_load  <= 1'b0;
      bus.tx_nack  <= 1'b0;

      // Bus conditions override everything; a partial byte is simply dropped.
      if (bus.start_found) begin
        state      <= ADDR;
        bit_cnt    <= '0;
        phase      <= 1'b0;
        bus.sda_oe <= 1'b0;
      end else if (bus.stop_found) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        phase      <= 1'b0;
        bus.sda_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bus.sda_oe <= 1'b0;
          end

          ADDR: begin
            if (scl_rise) begin
              bus.starting_byte <= {bus.starting_byte[NBITS-2:0], sda_sync};
              if (bit_cnt == LAST_BIT) begin
                state   <= ADDR_DEC;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end

          // starting_byte is complete here, so decode's match is valid this cycle.
          ADDR_DEC: begin
            bit_cnt <= '0;
            phase   <= 1'b0;
            state   <= bus.address_match ? ADDR_ACK : WAIT_STOP;
          end

          // First fall pulls SDA low for the ACK bit, second fall (after the
          // ACK's rise) lets go and moves on to the data phase.
          ADDR_ACK, RX_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                bus.sda_oe  <= 1'b1;
                bus.sda_out <= 1'b0;
                phase       <= 1'b1;
              end else begin
                bus.sda_oe <= 1'b0;
                phase      <= 1'b0;
                bit_cnt    <= '0;
                if (state == ADDR_ACK && bus.rw_mode) begin
                  state       <= TX_BYTE;
                  bus.tx_load <= 1'b1;
                end else begin
                  state <= RX_BYTE;
                end
              end
            end
          end

          RX_BYTE: begin
            if (scl_rise) begin
              rx_shift <= {rx_shift[NBITS-3:0], sda_sync};
              if (bit_cnt == LAST_BIT) begin
                bus.rx_data  <= {rx_shift, sda_sync};
                bus.rx_valid <= 1'b1;
                state        <= RX_ACK;
                bit_cnt      <= '0;
                phase        <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end

          // The tx_load cycle captures tx_data and drives its MSB straight away;
          // later bits follow on each scl fall until the 8th rise has passed.
          TX_BYTE: begin
            if (bus.tx_load) begin
              tx_shift    <= bus.tx_data[NBITS-2:0];
              bus.sda_out <= 1'b0;
              bus.sda_oe  <= ~bus.tx_data[NBITS-1];
            end else if (scl_rise) begin
              if (bit_cnt == LAST_BIT) begin
                phase <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (scl_fall) begin
              if (phase) begin
                bus.sda_oe <= 1'b0;
                state      <= TX_CHK;
                phase      <= 1'b0;
                bit_cnt    <= '0;
              end else begin
                tx_shift   <= {tx_shift[NBITS-3:0], 1'b0};
                bus.sda_oe <= ~tx_shift[NBITS-2];
              end
            end
          end

          TX_CHK: begin
            if (scl_rise && !phase) begin
              if (!sda_sync) begin
                phase <= 1'b1;
              end else begin
                bus.tx_nack <= 1'b1;
                state       <= WAIT_STOP;
              end
            end else if (scl_fall && phase) begin
              state       <= TX_BYTE;
              bus.tx_load <= 1'b1;
              phase       <= 1'b0;
              bit_cnt     <= '0;
            end
          end

          WAIT_STOP: begin
            bus.sda_oe <= 1'b0;
          end

          default: begin
            state      <= IDLE;
            bus.sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
